// File: rtl/mau_controller.sv
// mau_controller: sequences host load/store, arithmetic and copy transfers between four matrix BRAMs.
module mau_controller #(
    parameter int matrix_dim = 8,
    parameter int wait_limit = 255
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] host_instruction,
    input  logic       instr_valid,
    input  logic       data_valid,
    input  logic       data_out_ready,
    input  logic       arith_done,
    output logic       busy_flag,
    output logic       error_flag,
    output logic       data_out_valid,
    output logic [8:0] offset,
    output logic [1:0] host_out_sel,
    output logic [3:0] line_read_from_host,
    output logic [3:0] chunk_read_from_bram,
    output logic [1:0] aa_mux_sel,
    output logic [1:0] dd_mux_sel,
    output logic [1:0] arithmetic_mux_sel,
    output logic       bram_in_mux_sel,
    output logic [1:0] bram_copy_mux_sel,
    output logic       arith_start
);
    localparam int n_bytes = matrix_dim * matrix_dim;
    localparam int ww = (wait_limit < 2) ? 1 : $clog2(wait_limit + 1);
    localparam logic [8:0] last_byte = 9'(n_bytes - 1);
    localparam logic [ww-1:0] last_wait = ww'(wait_limit - 1);
    localparam logic [2:0] op_load = 3'b001, op_store = 3'b010, op_copy = 3'b111;
    typedef enum logic [2:0] {IDLE, LOAD, STORE, EXEC, WAIT, WRITE} state_t;
    state_t state;
    logic [2:0] opc;
    logic [1:0] a, b;
    logic [8:0] cnt;
    logic [ww-1:0] wcnt;
    logic [2:0] op_in;
    logic arith_phase, copy_wr, unused_bit;
    assign op_in = host_instruction[7:5];
    assign unused_bit = host_instruction[0];
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            opc <= '0;
            a <= '0;
            b <= '0;
            cnt <= '0;
            wcnt <= '0;
            error_flag <= 1'b0;
        end else begin
            case (state)
                IDLE: if (instr_valid) begin
                    opc <= op_in;
                    a <= host_instruction[4:3];
                    b <= host_instruction[2:1];
                    cnt <= '0;
                    wcnt <= '0;
                    state <= op_in == op_load  ? LOAD  :
                             op_in == op_store ? STORE :
                             op_in == op_copy  ? WRITE :
                             op_in == 3'b000   ? IDLE  : EXEC;
                end
                LOAD: if (data_valid) begin
                    cnt <= cnt + 9'd1;
                    if (cnt == last_byte) state <= IDLE;
                end
                STORE: if (data_out_ready) begin
                    cnt <= cnt + 9'd1;
                    if (cnt == last_byte) state <= IDLE;
                end
                EXEC: state <= WAIT;
                // a result arriving on the final allowed cycle still wins over the timeout
                WAIT: if (arith_done) state <= WRITE;
                else if (wcnt == last_wait) begin
                    error_flag <= 1'b1;
                    state <= IDLE;
                end else wcnt <= wcnt + 1'b1;
                WRITE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
    assign arith_phase = (state == EXEC || state == WAIT || state == WRITE) && opc != op_copy;
    assign copy_wr = state == WRITE && opc == op_copy;
    assign busy_flag = state != IDLE;
    assign data_out_valid = state == STORE;
    assign offset = (state == LOAD || state == STORE) ? cnt : '0;
    assign host_out_sel = state == STORE ? a : '0;
    assign line_read_from_host = (state == LOAD && data_valid) ? 4'b0001 << a : '0;
    assign chunk_read_from_bram = state == WRITE ? 4'b0001 << a : '0;
    assign aa_mux_sel = arith_phase ? a : '0;
    assign dd_mux_sel = arith_phase ? b : '0;
    assign arithmetic_mux_sel = arith_phase ? 2'(opc - 3'd3) : '0;
    assign bram_in_mux_sel = copy_wr;
    assign bram_copy_mux_sel = copy_wr ? b : '0;
    assign arith_start = state == EXEC;
endmodule

// File: tb/tb_mau_controller.sv
// tb_mau_controller: directed stimulus with a queued scoreboard checked by a negedge monitor.
module tb_mau_controller;
    logic clk = 1'b0, reset = 1'b0;
    logic [7:0] host_instruction = '0;
    logic instr_valid = 1'b0, data_valid = 1'b0, data_out_ready = 1'b0, arith_done = 1'b0;
    logic busy_flag, error_flag, data_out_valid, bram_in_mux_sel, arith_start;
    logic [8:0] offset;
    logic [1:0] host_out_sel, aa_mux_sel, dd_mux_sel, arithmetic_mux_sel, bram_copy_mux_sel;
    logic [3:0] line_read_from_host, chunk_read_from_bram;
    logic [31:0] exp_q[$];
    int checks = 0, errors = 0;

    mau_controller dut (
        .clk(clk), .reset(reset), .host_instruction(host_instruction),
        .instr_valid(instr_valid), .data_valid(data_valid), .data_out_ready(data_out_ready),
        .arith_done(arith_done), .busy_flag(busy_flag), .error_flag(error_flag),
        .data_out_valid(data_out_valid), .offset(offset), .host_out_sel(host_out_sel),
        .line_read_from_host(line_read_from_host), .chunk_read_from_bram(chunk_read_from_bram),
        .aa_mux_sel(aa_mux_sel), .dd_mux_sel(dd_mux_sel), .arithmetic_mux_sel(arithmetic_mux_sel),
        .bram_in_mux_sel(bram_in_mux_sel), .bram_copy_mux_sel(bram_copy_mux_sel),
        .arith_start(arith_start)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] ev_line(logic [3:0] s, int o);
        return {4'd1, 15'd0, s, 9'(o)};
    endfunction
    function automatic logic [31:0] ev_store(logic [1:0] s, int o);
        return {4'd2, 17'd0, s, 9'(o)};
    endfunction
    function automatic logic [31:0] ev_start(logic [1:0] aa, logic [1:0] dd, logic [1:0] ar);
        return {4'd3, 22'd0, aa, dd, ar};
    endfunction
    function automatic logic [31:0] ev_chunk(logic [3:0] s, logic in_sel, logic [5:0] sels);
        return {4'd4, 17'd0, s, in_sel, sels};
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", name, got, exp);
        end
    endtask

    task automatic observe(input string name, input logic [31:0] got);
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL %s unexpected event got=%0h expected=none", name, got);
        end else begin
            logic [31:0] e;
            e = exp_q.pop_front();
            if (got !== e) begin
                errors++;
                $display("FAIL %s got=%0h expected=%0h", name, got, e);
            end
        end
    endtask

    always @(negedge clk) begin
        if (line_read_from_host != 4'd0) observe("line", {4'd1, 15'd0, line_read_from_host, offset});
        if (data_out_valid && data_out_ready) observe("store", {4'd2, 17'd0, host_out_sel, offset});
        if (arith_start) observe("start", {4'd3, 22'd0, aa_mux_sel, dd_mux_sel, arithmetic_mux_sel});
        if (chunk_read_from_bram != 4'd0)
            observe("chunk", {4'd4, 17'd0, chunk_read_from_bram, bram_in_mux_sel,
                bram_in_mux_sel ? {4'd0, bram_copy_mux_sel} : {aa_mux_sel, dd_mux_sel, arithmetic_mux_sel}});
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [2:0] op, input logic [1:0] a, input logic [1:0] b);
        host_instruction = {op, a, b, 1'b1};
        instr_valid = 1'b1;
        tick;
        instr_valid = 1'b0;
    endtask

    task automatic wait_idle(input int max, output int n);
        n = 0;
        while (busy_flag && n < max) begin
            tick;
            n++;
        end
    endtask

    task automatic load_run(input logic [1:0] a, input bit gaps, input bit hold);
        issue(3'b001, a, 2'd0);
        chk("load_busy", 32'(busy_flag), 32'd1);
        for (int i = 0; i < 64; i++) begin
            if (gaps) repeat ($urandom_range(0, 2)) tick;
            if (hold && i == 20) begin
                repeat (20) tick;
                chk("load_hold_offset", 32'(offset), 32'd20);
                chk("load_hold_busy", 32'(busy_flag), 32'd1);
            end
            data_valid = 1'b1;
            exp_q.push_back(ev_line(4'b0001 << a, i));
            tick;
            data_valid = 1'b0;
        end
        chk("load_done_busy", 32'(busy_flag), 32'd0);
        chk("load_done_offset", 32'(offset), 32'd0);
    endtask

    task automatic arith_run(input logic [2:0] op, input logic [1:0] a, input logic [1:0] b, input int delay);
        int n;
        issue(op, a, b);
        exp_q.push_back(ev_start(a, b, 2'(op - 3'd3)));
        repeat (delay) tick;
        arith_done = 1'b1;
        exp_q.push_back(ev_chunk(4'b0001 << a, 1'b0, {a, b, 2'(op - 3'd3)}));
        tick;
        arith_done = 1'b0;
        wait_idle(20, n);
        chk("arith_latency", 32'(2 + delay + n), 32'(3 + delay));
    endtask

    initial begin
        int n, idx, cyc;
        repeat (3) tick;
        chk("reset_outputs", {busy_flag, error_flag, data_out_valid, offset, host_out_sel,
            line_read_from_host, chunk_read_from_bram, aa_mux_sel, dd_mux_sel, arithmetic_mux_sel,
            bram_in_mux_sel, bram_copy_mux_sel, arith_start}, 32'd0);
        reset = 1'b1;
        load_run(2'd2, 1'b1, 1'b1);

        issue(3'b000, 2'd1, 2'd1);
        chk("nop_busy", 32'(busy_flag), 32'd0);

        issue(3'b010, 2'd1, 2'd0);
        idx = 0;
        cyc = 0;
        while (idx < 64 && cyc < 400) begin
            data_out_ready = (cyc % 3) != 1;
            if (cyc < 4) chk("store_valid", 32'(data_out_valid), 32'd1);
            if (data_out_ready) begin
                exp_q.push_back(ev_store(2'd1, idx));
                idx++;
            end
            tick;
            cyc++;
        end
        data_out_ready = 1'b0;
        chk("store_count", 32'(idx), 32'd64);
        chk("store_done_busy", 32'(busy_flag), 32'd0);
        chk("store_done_valid", 32'(data_out_valid), 32'd0);

        arith_run(3'b110, 2'd0, 2'd3, 5);
        arith_run(3'b101, 2'd2, 2'd1, 1);
        arith_run(3'b100, 2'd3, 2'd3, 2);

        issue(3'b011, 2'd1, 2'd2);
        exp_q.push_back(ev_start(2'd1, 2'd2, 2'd0));
        arith_done = 1'b1;
        tick;
        arith_done = 1'b0;
        chk("timeout_err_before", 32'(error_flag), 32'd0);
        wait_idle(400, n);
        chk("timeout_wait_cycles", 32'(n), 32'd255);
        chk("timeout_err_after", 32'(error_flag), 32'd1);
        load_run(2'd0, 1'b0, 1'b0);
        chk("timeout_err_sticky", 32'(error_flag), 32'd1);

        issue(3'b111, 2'd3, 2'd0);
        exp_q.push_back(ev_chunk(4'b1000, 1'b1, 6'd0));
        host_instruction = {3'b001, 2'd0, 2'd0, 1'b0};
        instr_valid = 1'b1;
        tick;
        instr_valid = 1'b0;
        chk("copy_latency_busy", 32'(busy_flag), 32'd0);
        tick;
        chk("copy_ignore_busy", 32'(busy_flag), 32'd0);

        issue(3'b001, 2'd1, 2'd0);
        for (int i = 0; i < 10; i++) begin
            data_valid = 1'b1;
            exp_q.push_back(ev_line(4'b0010, i));
            tick;
        end
        reset = 1'b0;
        #1;
        chk("midreset_outputs", {busy_flag, error_flag, data_out_valid, offset, host_out_sel,
            line_read_from_host, chunk_read_from_bram, aa_mux_sel, dd_mux_sel, arithmetic_mux_sel,
            bram_in_mux_sel, bram_copy_mux_sel, arith_start}, 32'd0);
        data_valid = 1'b0;
        tick;
        reset = 1'b1;
        load_run(2'd1, 1'b0, 1'b0);

        tick;
        tick;
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
